// File: rtl/bsg_cache_nb_pkg.sv
// Shared definitions for the non-blocking cache: load size encoding,
// read-miss response FSM states and width helpers used by the queue and its readers.
package bsg_cache_nb_pkg;

    // Load size encoding carried in every read-miss entry and on the hit path.
    typedef enum logic [1:0] {
        e_size_1B = 2'd0,
        e_size_2B = 2'd1,
        e_size_4B = 2'd2,
        e_size_8B = 2'd3
    } size_op_e;

    // States of the read-miss response drain engine.
    typedef enum logic {
        e_rmr_idle  = 1'b0,
        e_rmr_serve = 1'b1
    } rmr_state_e;

    // Index width that never collapses to zero bits for single-element arrays.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Width of one packed read-miss queue entry; the queue and every reader size storage with this.
    function automatic int rmq_entry_width(input int src_id_width,
                                           input int block_size_in_words,
                                           input int word_width);
        return src_id_width                      // src_id
             + safe_clog2(block_size_in_words)   // word_offset
             + 1                                 // mask_op
             + word_width / 8                    // mask
             + 2                                 // size_op
             + 1                                 // sigext_op
             + safe_clog2(word_width / 8)        // byte_sel
             + word_width                        // mshr_data
             + word_width / 8;                   // mshr_data_mask
    endfunction

endpackage

// File: rtl/bsg_cache_nb_read_miss_resp_if.sv
// Bundle of the start handshake, read-miss queue port and response port of the
// read-miss response block. The slave modport is the block's view, master the surroundings.
interface bsg_cache_nb_read_miss_resp_if
    import bsg_cache_nb_pkg::*;
#(
    parameter int block_size_in_words_p = 4,
    parameter int word_width_p          = 32,
    parameter int src_id_width_p        = 8,
    parameter int mshr_els_p            = 4
);
    localparam int lg_mshr_els_lp        = safe_clog2(mshr_els_p);
    localparam int lg_block_words_lp     = safe_clog2(block_size_in_words_p);
    localparam int data_mask_width_lp    = word_width_p / 8;
    localparam int lg_data_mask_width_lp = safe_clog2(word_width_p / 8);

    logic                                            start_v_i;
    logic                                            start_ready_o;
    logic [lg_mshr_els_lp-1:0]                       start_mshr_id_i;
    logic [block_size_in_words_p*word_width_p-1:0]   block_data_i;

    logic                                            rmq_v_o;
    logic [lg_mshr_els_lp-1:0]                       rmq_mshr_id_o;
    logic [src_id_width_p-1:0]                       rmq_src_id_i;
    logic [lg_block_words_lp-1:0]                    rmq_word_offset_i;
    logic                                            rmq_mask_op_i;
    logic [data_mask_width_lp-1:0]                   rmq_mask_i;
    size_op_e                                        rmq_size_op_i;
    logic                                            rmq_sigext_op_i;
    logic [lg_data_mask_width_lp-1:0]                rmq_byte_sel_i;
    logic [word_width_p-1:0]                         rmq_mshr_data_i;
    logic [data_mask_width_lp-1:0]                   rmq_mshr_data_mask_i;
    logic                                            rmq_yumi_o;
    logic                                            rmq_read_done_i;

    logic                                            v_o;
    logic                                            ready_i;
    logic [src_id_width_p-1:0]                       src_id_o;
    logic [word_width_p-1:0]                         data_o;
    logic                                            busy_o;

    modport slave (
        input  start_v_i, start_mshr_id_i, block_data_i,
        output start_ready_o,
        output rmq_v_o, rmq_mshr_id_o, rmq_yumi_o,
        input  rmq_src_id_i, rmq_word_offset_i, rmq_mask_op_i, rmq_mask_i,
        input  rmq_size_op_i, rmq_sigext_op_i, rmq_byte_sel_i,
        input  rmq_mshr_data_i, rmq_mshr_data_mask_i, rmq_read_done_i,
        output v_o, src_id_o, data_o, busy_o,
        input  ready_i
    );

    modport master (
        output start_v_i, start_mshr_id_i, block_data_i,
        input  start_ready_o,
        input  rmq_v_o, rmq_mshr_id_o, rmq_yumi_o,
        output rmq_src_id_i, rmq_word_offset_i, rmq_mask_op_i, rmq_mask_i,
        output rmq_size_op_i, rmq_sigext_op_i, rmq_byte_sel_i,
        output rmq_mshr_data_i, rmq_mshr_data_mask_i, rmq_read_done_i,
        input  v_o, src_id_o, data_o, busy_o,
        output ready_i
    );

endinterface

// File: rtl/bsg_cache_nb_load_align.sv
// Combinational load formatter shared by the hit path and the read-miss drain:
// overlays MSHR-held store bytes on the fetched word, then either byte-masks it
// or right-aligns, sizes and sign/zero-extends the requested field.
module bsg_cache_nb_load_align
    import bsg_cache_nb_pkg::*;
#(
    parameter int word_width_p = 32
) (
    input  logic [word_width_p-1:0]                    i_word,
    input  logic [word_width_p-1:0]                    i_mshr_data,
    input  logic [word_width_p/8-1:0]                  i_mshr_data_mask,
    input  logic                                       i_mask_op,
    input  logic [word_width_p/8-1:0]                  i_mask,
    input  size_op_e                                   i_size_op,
    input  logic                                       i_sigext,
    input  logic [safe_clog2(word_width_p/8)-1:0]      i_byte_sel,
    output logic [word_width_p-1:0]                    o_data
);

    localparam int bytes_lp = word_width_p / 8;

    logic [word_width_p-1:0] w_merged;
    logic [word_width_p-1:0] w_masked;
    logic [word_width_p-1:0] w_shifted;
    logic [word_width_p-1:0] w_extended;
    logic [7:0]              w_field_bits;
    logic                    w_sign;

    // Bytes still owned by the MSHR are newer than the refilled line, so they win.
    always_comb begin
        w_merged = i_word;
        for (int b = 0; b < bytes_lp; b++) begin
            if (i_mshr_data_mask[b]) begin
                w_merged[8*b +: 8] = i_mshr_data[8*b +: 8];
            end
        end
    end

    // Masked loads keep the selected bytes in place and zero the rest.
    always_comb begin
        w_masked = '0;
        for (int b = 0; b < bytes_lp; b++) begin
            if (i_mask[b]) begin
                w_masked[8*b +: 8] = w_merged[8*b +: 8];
            end
        end
    end

    assign w_shifted    = w_merged >> {i_byte_sel, 3'b000};
    assign w_field_bits = 8'd8 << i_size_op;

    // Pick the field's top bit and fill everything above the field with it (or zero).
    always_comb begin
        w_sign = 1'b0;
        for (int i = 0; i < word_width_p; i++) begin
            if (i == int'(w_field_bits) - 1) begin
                w_sign = w_shifted[i];
            end
        end
        w_extended = w_shifted;
        for (int i = 0; i < word_width_p; i++) begin
            if (i >= int'(w_field_bits)) begin
                w_extended[i] = i_sigext & w_sign;
            end
        end
    end

    // A field as wide as the word needs neither shift nor extension.
    always_comb begin
        if (i_mask_op) begin
            o_data = w_masked;
        end else if (int'(w_field_bits) >= word_width_p) begin
            o_data = w_merged;
        end else begin
            o_data = w_extended;
        end
    end

endmodule

// File: rtl/bsg_dff_en.sv
// Plain enable flop bank without reset; holds its value until the next enabled load.
module bsg_dff_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] r_data;

    // Capture the input only on enabled cycles.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_data <= data_i;
        end
    end

    assign data_o = r_data;

endmodule

// File: rtl/bsg_cache_nb_read_miss_resp.sv
// Read-miss response engine: after an MSHR refill it launches a read of that
// MSHR's miss queue, pops each entry, formats the load from the captured line
// and returns it through a one-entry valid/ready output register.
module bsg_cache_nb_read_miss_resp
    import bsg_cache_nb_pkg::*;
#(
    parameter int block_size_in_words_p = 4,
    parameter int word_width_p          = 32,
    parameter int src_id_width_p        = 8,
    parameter int mshr_els_p            = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    bsg_cache_nb_read_miss_resp_if.slave  io
);

    localparam int lg_mshr_els_lp    = safe_clog2(mshr_els_p);
    localparam int lg_block_words_lp = safe_clog2(block_size_in_words_p);
    localparam int block_width_lp    = block_size_in_words_p * word_width_p;

    rmr_state_e                  r_state;
    logic [lg_mshr_els_lp-1:0]   r_mshr_id;
    logic                        r_v;
    logic [src_id_width_p-1:0]   r_src_id;
    logic [word_width_p-1:0]     r_data;

    logic [block_width_lp-1:0]   w_block;
    logic [word_width_p-1:0]     w_word;
    logic [word_width_p-1:0]     w_load_data;
    logic                        w_start_accept;
    logic                        w_yumi;
    logic                        w_done;

    // The queue's launch strobe is the accept itself, so the next cycle already has a head entry.
    assign w_start_accept = (r_state == e_rmr_idle) & io.start_v_i & ~reset_i;
    // Pop whenever the output register is empty or being drained this cycle.
    assign w_yumi = (r_state == e_rmr_serve) & (~r_v | io.ready_i);
    assign w_done = w_yumi & io.rmq_read_done_i;

    bsg_dff_en #(
        .width_p(block_width_lp)
    ) line_capture (
        .clk_i  (clk_i),
        .en_i   (w_start_accept),
        .data_i (io.block_data_i),
        .data_o (w_block)
    );

    // Select the word the head entry refers to out of the captured line.
    always_comb begin
        w_word = '0;
        for (int w = 0; w < block_size_in_words_p; w++) begin
            if (io.rmq_word_offset_i == lg_block_words_lp'(w)) begin
                w_word = w_block[w*word_width_p +: word_width_p];
            end
        end
    end

    bsg_cache_nb_load_align #(
        .word_width_p(word_width_p)
    ) load_align (
        .i_word           (w_word),
        .i_mshr_data      (io.rmq_mshr_data_i),
        .i_mshr_data_mask (io.rmq_mshr_data_mask_i),
        .i_mask_op        (io.rmq_mask_op_i),
        .i_mask           (io.rmq_mask_i),
        .i_size_op        (io.rmq_size_op_i),
        .i_sigext         (io.rmq_sigext_op_i),
        .i_byte_sel       (io.rmq_byte_sel_i),
        .o_data           (w_load_data)
    );

    // Idle/serve control: leave serve on the pop of the last queued entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= e_rmr_idle;
            r_mshr_id <= '0;
        end else begin
            case (r_state)
                e_rmr_idle: begin
                    if (w_start_accept) begin
                        r_state   <= e_rmr_serve;
                        r_mshr_id <= io.start_mshr_id_i;
                    end
                end
                e_rmr_serve: begin
                    if (w_done) begin
                        r_state <= e_rmr_idle;
                    end
                end
                default: r_state <= e_rmr_idle;
            endcase
        end
    end

    // One-entry output register: load on pop, hold under backpressure, empty on drain.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v      <= 1'b0;
            r_src_id <= '0;
            r_data   <= '0;
        end else if (w_yumi) begin
            r_v      <= 1'b1;
            r_src_id <= io.rmq_src_id_i;
            r_data   <= w_load_data;
        end else if (io.ready_i) begin
            r_v <= 1'b0;
        end
    end

    assign io.start_ready_o = (r_state == e_rmr_idle);
    assign io.rmq_v_o       = w_start_accept;
    assign io.rmq_mshr_id_o = (r_state == e_rmr_idle) ? io.start_mshr_id_i : r_mshr_id;
    assign io.rmq_yumi_o    = w_yumi;
    assign io.v_o           = r_v;
    assign io.src_id_o      = r_src_id;
    assign io.data_o        = r_data;
    assign io.busy_o        = (r_state != e_rmr_idle) | r_v;

endmodule

// File: doc/bsg_cache_nb_read_miss_resp.md
# bsg_cache_nb_read_miss_resp

Drains one MSHR's read-miss queue after its refill completes and returns load data to requesters. Sits between the refill/MSHR data path and the cache response port. Launches a read of the queue for the selected MSHR, then pops each stored miss entry. For each entry it merges MSHR-held bytes over the refilled block word, then aligns, sizes and sign-extends (or masks) the word. The result goes out through a one-entry valid/ready output register.

## Interface
- block_size_in_words_p, none (required): words per cache block
- word_width_p, none (required): data word width; multiple of 8, max 64
- src_id_width_p, none (required): requester id width
- mshr_els_p, none (required): number of MSHRs; lg_mshr_els_lp = BSG_SAFE_CLOG2(mshr_els_p)
- clk_i  in  1  single clock
- reset_i  in  1  synchronous, active-high reset
- start_v_i  in  1  refill of an MSHR with queued read misses is complete
- start_ready_o  out  1  block idle; start accepted when start_v_i & start_ready_o
- start_mshr_id_i  in  lg_mshr_els_lp  MSHR to serve
- block_data_i  in  block_size_in_words_p*word_width_p  refilled line; sampled on start accept
- rmq_v_o  out  1  read-launch strobe to read-miss queue (write_not_read=0)
- rmq_mshr_id_o  out  lg_mshr_els_lp  MSHR id for launch; equals start_mshr_id_i in launch cycle
- rmq_src_id_i, rmq_word_offset_i, rmq_mask_op_i, rmq_mask_i, rmq_size_op_i, rmq_sigext_op_i, rmq_byte_sel_i, rmq_mshr_data_i, rmq_mshr_data_mask_i  in  per queue entry format  current head entry
- rmq_yumi_o  out  1  head entry consumed this cycle
- rmq_read_done_i  in  1  consumed entry is the last; combinational from rmq_yumi_o
- v_o  out  1  response valid
- ready_i  in  1  downstream accepts response
- src_id_o  out  src_id_width_p  requester id of response
- data_o  out  word_width_p  load result
- busy_o  out  1  state != IDLE or v_o

## Operation
- FSM states IDLE, SERVE.
- IDLE: start_ready_o=1. On start_v_i, the block captures block_data_i and start_mshr_id_i. It pulses rmq_v_o for exactly that cycle and moves to SERVE.
- SERVE: the rmq_* entry inputs are valid every cycle. rmq_yumi_o = ~v_o | ready_i; output register load uses the same term.
- On rmq_yumi_o & rmq_read_done_i, go to IDLE. start_ready_o stays 0 in SERVE.
- Merge: w = block word[rmq_word_offset_i]. Each byte b with rmq_mshr_data_mask_i[b]=1 is replaced by rmq_mshr_data_i byte b.
- mask_op=1: data = w with bytes where rmq_mask_i[b]=0 forced to 0. No shift, no sign extension.
- mask_op=0: s = w >> (8*byte_sel); keep low 8<<size_op bits; upper bits = sigext ? msb of kept field : 0. If 8<<size_op >= word_width_p, data = w unshifted.
- Output register: v_o set on load. Cleared on ready_i without a new load. It holds src_id_o/data_o stable while v_o & ~ready_i.

## Timing
- Reset: state IDLE, v_o=0, rmq_v_o=0, rmq_yumi_o=0, start_ready_o=1, busy_o=0, data_o/src_id_o=0.
- Start accepted cycle N. First entry is presented at N+1 and can be popped at N+1. First response v_o=1 at N+2.
- Throughput is one entry per cycle while ready_i=1. With k entries and no backpressure, the last v_o is at N+1+k.
- Backpressure: v_o & ~ready_i stalls rmq_yumi_o. Entry inputs are held by the queue.
- Done and next start: a start is accepted in the cycle after the done pop. The output register may still hold the last response. This is legal; the next launch overlaps the drain.
- The block never sees an empty queue; start_v_i is asserted only for MSHRs with at least one queued miss.
- Reset mid-SERVE: back to IDLE next edge. Pending output is dropped. The queue is reset by the same reset_i.

## Structure
- bsg_cache_nb_pkg holds the size_op encoding enum: 0=1B, 1=2B, 2=4B, 3=8B. The read-miss entry struct width macro is shared with the queue and lives there too.
- One sub-module: bsg_cache_nb_load_align. It is combinational and covers merge, mask and extension. It is reused by the hit path.
- The line capture uses bsg_dff_en. The output stage is a one-entry pipe register.

## Test plan
All scenarios use word_width 32, 4 words per block, block words 0x44332211, 0x88776655, 0xCCBBAA99, 0xF0EEDDCC.
- Single entry: word_offset 1, size 0, byte_sel 3, sigext 1 -> data_o 0xFFFFFF88, v_o at N+2, then IDLE.
- Merge: word 0, mshr_data 0x0000AB00, mshr_data_mask 0b0010, size 2 -> 0x4433AB11.
- mask_op: word 2, mask 0b0101 -> 0x00BB0099. Size 1, byte_sel 2, sigext 0 on word 3 -> 0x0000F0EE.
- Three entries with ready_i held 0 for 3 cycles mid-stream -> no pop while stalled, output stable, responses in FIFO order, done on the 3rd pop.
- Back-to-back starts: second start_v_i asserted while SERVE -> start_ready_o=0. Second start is accepted the cycle after done.
- Reset asserted in SERVE with v_o=1 -> next cycle v_o=0, IDLE, start_ready_o=1.
